// File: rtl/store_rmw_unit_pkg.sv
// store_rmw_unit_pkg: op encodings and FSM state encoding for the store engine
package store_rmw_unit_pkg;
  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/store_rmw_unit_merge.sv
// store_rmw_unit_merge: merges new low halfword/byte into an old memory word
module store_rmw_unit_merge
  import store_rmw_unit_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged
);
  // lane is always the low half or low byte; address bits never select lanes
  always_comb
    merged = op == OP_SH ? {old_word[31:16], new_data[15:0]} :
             op == OP_SB ? {old_word[31:8], new_data[7:0]} : new_data;
endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: sequential SW/SH/SB store engine driving a single-port memory
module store_rmw_unit
  import store_rmw_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] b_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, wdata_q, wdata_d, merged;
  store_rmw_unit_merge u_merge (
    .op      (op_q),
    .old_word(mem_rdata),
    .new_data(data_q),
    .merged  (merged)
  );
  // state and capture registers; reset clears everything so no merge survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_SW;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
    end
  end
  // next state; request captured only in IDLE, merged word captured at end of WAIT
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op_e'(op);
        addr_d  = addr;
        data_d  = b_out;
        state_d = op_e'(op) == OP_SW  ? WRITE :
                  op_e'(op) == OP_RSV ? DONE  : READ;
      end
      READ:  state_d = WAIT;
      WAIT: begin
        wdata_d = merged;
        state_d = WRITE;
      end
      WRITE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = state_q == DONE && op_q == OP_RSV;
  assign mem_wr    = state_q == WRITE;
  assign mem_addr  = addr_q;
  assign mem_wdata = op_q == OP_SW ? data_q : wdata_q;
endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: directed vector bench for the store engine with a memory model
module tb_store_rmw_unit;
  logic        clk = 0, reset_n = 0, start = 0;
  logic [1:0]  op = 0;
  logic [31:0] addr = 0, b_out = 0, mem_rdata;
  logic        busy, done, err, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem [0:63];
  logic        pl_en = 0;
  logic [5:0]  pl_idx = 0;
  logic [31:0] pl_data = 0;
  int errors = 0, checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr, b, init, exp_wdata, exp_mem;
    int          wcyc, dcyc, icyc, rd;
    logic        exp_err;
  } vec_t;
  vec_t vt [6];

  store_rmw_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr),
    .b_out(b_out), .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1; pl_idx = a[7:2]; pl_data = d;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " mem_wr"}, 32'(mem_wr), 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int wcyc = 0, dcyc = 0, icyc = 0, rd = 0, nwr = 0, errc = 0;
    logic [31:0] wd = 0, wa = 0;
    logic e = 0;
    preload(v.addr, v.init);
    op = v.op; addr = v.addr; b_out = v.b; start = 1;
    @(posedge clk);
    #1 start = 0; b_out = ~v.b; addr = 32'hFFFF_FFFC; op = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wr) begin nwr++; wcyc = c; wd = mem_wdata; wa = mem_addr; end
      if (done) begin dcyc = c; e = err; end
      if (err && !done) errc++;
      if (busy && !mem_wr && !done) rd++;
      if (!busy && icyc == 0) icyc = c;
    end
    chk({tag, " write cycle"}, wcyc, v.wcyc);
    chk({tag, " write count"}, nwr, (v.wcyc != 0) ? 1 : 0);
    if (v.wcyc != 0) begin
      chk({tag, " write addr"}, wa, v.addr);
      chk({tag, " write data"}, wd, v.exp_wdata);
    end
    chk({tag, " done cycle"}, dcyc, v.dcyc);
    chk({tag, " err"}, 32'(e), 32'(v.exp_err));
    chk({tag, " stray err"}, errc, 0);
    chk({tag, " idle cycle"}, icyc, v.icyc);
    chk({tag, " read cycles"}, rd, v.rd);
    chk({tag, " memory"}, mem[v.addr[7:2]], v.exp_mem);
  endtask

  initial begin
    int w1c = 0, w2c = 0, d1c = 0, d2c = 0;
    logic [31:0] w1d = 0, w2d = 0;
    logic b5 = 1, b6 = 0, b10 = 1;
    vec_t sw2;
    vt[0] = '{op:2'b00, addr:32'h40, b:32'hDEADBEEF, init:32'h55555555, exp_wdata:32'hDEADBEEF,
              exp_mem:32'hDEADBEEF, wcyc:1, dcyc:2, icyc:3, rd:0, exp_err:1'b0};
    vt[1] = '{op:2'b01, addr:32'h40, b:32'hAAAABBBB, init:32'h11223344, exp_wdata:32'h1122BBBB,
              exp_mem:32'h1122BBBB, wcyc:3, dcyc:4, icyc:5, rd:2, exp_err:1'b0};
    vt[2] = '{op:2'b10, addr:32'h44, b:32'h000000CC, init:32'h11223344, exp_wdata:32'h112233CC,
              exp_mem:32'h112233CC, wcyc:3, dcyc:4, icyc:5, rd:2, exp_err:1'b0};
    vt[3] = '{op:2'b10, addr:32'h47, b:32'h12345678, init:32'hCAFEF00D, exp_wdata:32'hCAFEF078,
              exp_mem:32'hCAFEF078, wcyc:3, dcyc:4, icyc:5, rd:2, exp_err:1'b0};
    vt[4] = '{op:2'b01, addr:32'h4A, b:32'h00000000, init:32'hFFFFFFFF, exp_wdata:32'hFFFF0000,
              exp_mem:32'hFFFF0000, wcyc:3, dcyc:4, icyc:5, rd:2, exp_err:1'b0};
    vt[5] = '{op:2'b11, addr:32'h50, b:32'h12345678, init:32'h0BADF00D, exp_wdata:32'h0,
              exp_mem:32'h0BADF00D, wcyc:0, dcyc:1, icyc:2, rd:0, exp_err:1'b1};
    sw2   = '{op:2'b00, addr:32'h48, b:32'h01020304, init:32'h0, exp_wdata:32'h01020304,
              exp_mem:32'h01020304, wcyc:1, dcyc:2, icyc:3, rd:0, exp_err:1'b0};

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1;

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

    preload(32'h60, 32'hA5A5A5A5);
    op = 2'b01; addr = 32'h60; b_out = 32'h00001234; start = 1;
    @(posedge clk);
    #1 b_out = 32'hFFFF5678;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_wr) begin
        if (w1c == 0) begin w1c = c; w1d = mem_wdata; end
        else begin w2c = c; w2d = mem_wdata; end
      end
      if (done) begin
        if (d1c == 0) d1c = c; else d2c = c;
      end
      if (c == 5) b5 = busy;
      if (c == 6) b6 = busy;
      if (c == 10) b10 = busy;
      if (c == 9) start = 0;
    end
    chk("held first write cycle", w1c, 3);
    chk("held first write data", w1d, 32'hA5A51234);
    chk("held first done", d1c, 4);
    chk("held idle gap busy", 32'(b5), 0);
    chk("held second start busy", 32'(b6), 1);
    chk("held second write cycle", w2c, 8);
    chk("held second write data", w2d, 32'hA5A55678);
    chk("held second done", d2c, 9);
    chk("held final idle", 32'(b10), 0);

    preload(32'h44, 32'h11223344);
    op = 2'b10; addr = 32'h44; b_out = 32'h000000CC; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(negedge clk);
    chk("rst write active", 32'(mem_wr), 1);
    reset_n = 0;
    #1;
    chk_zero("rst mid-write");
    @(negedge clk);
    chk("rst memory kept", mem[6'h11], 32'h11223344);
    reset_n = 1;
    run_vec(sw2, "post-reset sw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Sequential store engine on the CPU's memory write path. It accepts a store request for a word, halfword or byte and drives the single-port data memory itself. A full-word store goes straight to a write. A partial store does a read-modify-write: it reads the old word, merges in the new low halfword or byte, and writes the word back. It sits between the multicycle control unit and the memory, and lets the control unit hand off SW/SH/SB with one start/done handshake.

## Interface
Parameters:
- none; widths fixed at 32-bit data/address.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  store kind: 00 SW, 01 SH, 10 SB, 11 reserved
- addr  in  32  byte address, used unmodified as the memory address
- b_out  in  32  store data (B register)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for a reserved op
- mem_addr  out  32  memory address
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after address presentation with mem_wr=0

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE with start=1:
  - Capture addr→addr_q, b_out→data_q, op→op_q.
  - Next state by op: SW→WRITE; SH/SB→READ; 11→DONE with err.
- READ: mem_addr=addr_q, mem_wr=0. Next state WAIT.
- WAIT: mem_wr=0. At the end of the cycle, capture the merged word into wdata_q. Next state WRITE.
  - SH: wdata_q = {mem_rdata[31:16], data_q[15:0]}
  - SB: wdata_q = {mem_rdata[31:8], data_q[7:0]}
- WRITE: mem_wr=1.
  - mem_wdata = data_q for SW; mem_wdata = wdata_q for SH/SB.
  - Next state DONE.
- DONE: done=1 (and err=1 if op_q=11). Next state IDLE.
- Merge position is always the low half or low byte. addr[1:0] does not select lanes; this matches the CPU's load/store lane convention.
- start outside IDLE is ignored, including in DONE. No queuing.
- op, addr and b_out may change freely after the capture edge.
- Reserved op: never asserts mem_wr and never reads memory.

## Timing
- Reset values: state IDLE; addr_q, data_q, wdata_q, op_q = 0.
  - Consequently busy=0, done=0, err=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- mem_wr, busy, done and err decode from state only. Asynchronous reset therefore drops mem_wr in the same instant, including mid-WRITE. No partial merge survives a reset.
- mem_addr=addr_q in all states. mem_wdata is held stable throughout WRITE.
- Latency, counting the start edge as edge 0:
  - SW: WRITE during cycle 1, done during cycle 2, IDLE at cycle 3.
  - SH/SB: READ cycle 1, WAIT cycle 2 (rdata sampled at its closing edge), WRITE cycle 3, done cycle 4, IDLE at cycle 5.
  - Reserved op: done+err during cycle 1.
- Back-to-back throughput: next start is accepted at earliest in the IDLE cycle after done. This gives 3 cycles per SW and 5 per SH/SB.

## Structure
- Shared include store_defs.vh holds:
  - op encodings OP_SW=2'b00, OP_SH=2'b01, OP_SB=2'b10, OP_RSV=2'b11
  - state localparams: IDLE, READ, WAIT, WRITE, DONE (3-bit encoding)
- Sub-module store_merge: combinational, inputs (op, old word, new data), output the merged word. It is reused for the WAIT capture and is unit-testable alone.
- Top: FSM, capture registers and output decode.

## Test plan
- SW: addr=0x40, b_out=0xDEADBEEF, start.
  - mem_wr=1 in cycle 1 with mem_addr=0x40, mem_wdata=0xDEADBEEF.
  - done in cycle 2; no read cycle.
- SH: memory[0x40]=0x11223344, b_out=0xAAAABBBB.
  - Read in cycles 1–2; write in cycle 3 with mem_wdata=0x1122BBBB.
  - done in cycle 4.
- SB: memory[0x44]=0x11223344, b_out=0x000000CC.
  - Write in cycle 3 with mem_wdata=0x112233CC.
  - done in cycle 4.
- Reserved op=11: done=err=1 in cycle 1; mem_wr never asserted; busy low at cycle 2.
- Start held high continuously with SH: a second operation begins only in the IDLE cycle after done. Changing b_out mid-operation does not alter mem_wdata.
- Reset mid-operation: reset_n low during WRITE of an SB.
  - mem_wr drops immediately and all outputs are 0.
  - After release the block is in IDLE and the next SW completes in 3 cycles.
